// File: rtl/csr_access_unit_pkg.sv
// Shared constants and types for the machine-mode CSR access unit.
package csr_access_unit_pkg;

    localparam int XLEN    = 32;
    localparam int NUM_CSR = 8;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    localparam int IDX_MSTATUS   = 0;
    localparam int IDX_MISA      = 1;
    localparam int IDX_MIE       = 2;
    localparam int IDX_MIP       = 3;
    localparam int IDX_MVENDORID = 4;
    localparam int IDX_MARCHID   = 5;
    localparam int IDX_MIMPID    = 6;
    localparam int IDX_MHARTID   = 7;

    typedef enum logic [2:0] {
        F3_RW  = 3'b001,
        F3_RS  = 3'b010,
        F3_RC  = 3'b011,
        F3_RWI = 3'b101,
        F3_RSI = 3'b110,
        F3_RCI = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/csr_access_unit_addr_decode.sv
// CSR address decoder: one-hot register select plus mapped/read-only/privilege attributes.
module csr_addr_decode
    import csr_access_unit_pkg::*;
(
    input  logic [11:0]        addr_i,
    output logic [NUM_CSR-1:0] sel_o,
    output logic               mapped_o,
    output logic               read_only_o,
    output logic [1:0]         min_priv_o
);

    always_comb begin
        sel_o = '0;
        case (addr_i)
            ADDR_MSTATUS:   sel_o[IDX_MSTATUS]   = 1'b1;
            ADDR_MISA:      sel_o[IDX_MISA]      = 1'b1;
            ADDR_MIE:       sel_o[IDX_MIE]       = 1'b1;
            ADDR_MIP:       sel_o[IDX_MIP]       = 1'b1;
            ADDR_MVENDORID: sel_o[IDX_MVENDORID] = 1'b1;
            ADDR_MARCHID:   sel_o[IDX_MARCHID]   = 1'b1;
            ADDR_MIMPID:    sel_o[IDX_MIMPID]    = 1'b1;
            ADDR_MHARTID:   sel_o[IDX_MHARTID]   = 1'b1;
            default:        sel_o                = '0;
        endcase
    end

    assign mapped_o    = |sel_o;
    assign read_only_o = (addr_i[11:10] == 2'b11);
    assign min_priv_o  = addr_i[9:8];

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write engine: IDLE -> READ -> (WRITE) -> RESP, one instruction in flight.
module csr_access_unit
    import csr_access_unit_pkg::*;
(
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [4:0]      req_zimm,
    input  logic            req_rs1_idx_zero,
    input  logic [1:0]      req_priv,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_illegal,
    input  logic [XLEN-1:0] csr_rd_mstatus,
    input  logic [XLEN-1:0] csr_rd_misa,
    input  logic [XLEN-1:0] csr_rd_mie,
    input  logic [XLEN-1:0] csr_rd_mip,
    input  logic [XLEN-1:0] csr_rd_mvendorid,
    input  logic [XLEN-1:0] csr_rd_marchid,
    input  logic [XLEN-1:0] csr_rd_mimpid,
    input  logic [XLEN-1:0] csr_rd_mhartid,
    output logic [7:0]      csr_we,
    output logic [XLEN-1:0] csr_wdata
);

    state_e          state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [11:0]     addr_q, addr_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [4:0]      zimm_q, zimm_d;
    logic            rs1z_q, rs1z_d;
    logic [1:0]      priv_q, priv_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic [NUM_CSR-1:0] sel;
    logic               mapped, read_only;
    logic [1:0]         min_priv;

    csr_addr_decode u_decode (
        .addr_i      (addr_q),
        .sel_o       (sel),
        .mapped_o    (mapped),
        .read_only_o (read_only),
        .min_priv_o  (min_priv)
    );

    logic [XLEN-1:0] old_val, src, new_val;
    logic            is_imm, f3_ok, write_req, illegal;

    assign old_val = ({XLEN{sel[IDX_MSTATUS]}}   & csr_rd_mstatus)
                   | ({XLEN{sel[IDX_MISA]}}      & csr_rd_misa)
                   | ({XLEN{sel[IDX_MIE]}}       & csr_rd_mie)
                   | ({XLEN{sel[IDX_MIP]}}       & csr_rd_mip)
                   | ({XLEN{sel[IDX_MVENDORID]}} & csr_rd_mvendorid)
                   | ({XLEN{sel[IDX_MARCHID]}}   & csr_rd_marchid)
                   | ({XLEN{sel[IDX_MIMPID]}}    & csr_rd_mimpid)
                   | ({XLEN{sel[IDX_MHARTID]}}   & csr_rd_mhartid);

    // funct3[2] selects the immediate forms; funct3[1:0] is the operation.
    assign is_imm = funct3_q[2];
    assign src    = is_imm ? {{(XLEN-5){1'b0}}, zimm_q} : rs1_q;
    assign f3_ok  = (funct3_q[1:0] != 2'b00);

    always_comb begin
        write_req = 1'b0;
        new_val   = src;
        case (funct3_q[1:0])
            2'b01: write_req = 1'b1;
            2'b10: begin
                write_req = is_imm ? (zimm_q != 5'd0) : !rs1z_q;
                new_val   = old_val | src;
            end
            2'b11: begin
                write_req = is_imm ? (zimm_q != 5'd0) : !rs1z_q;
                new_val   = old_val & ~src;
            end
            default: write_req = 1'b0;
        endcase
    end

    assign illegal = !f3_ok || !mapped || (priv_q < min_priv) || (write_req && read_only);

    always_comb begin
        state_d   = state_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        rs1_d     = rs1_q;
        zimm_d    = zimm_q;
        rs1z_d    = rs1z_q;
        priv_d    = priv_q;
        rdata_d   = rdata_q;
        illegal_d = illegal_q;
        wdata_d   = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    rs1_d    = req_rs1;
                    zimm_d   = req_zimm;
                    rs1z_d   = req_rs1_idx_zero;
                    priv_d   = req_priv;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                rdata_d   = illegal ? '0 : old_val;
                illegal_d = illegal;
                if (!illegal && write_req) begin
                    wdata_d = new_val;
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  if (resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q   <= ST_IDLE;
            funct3_q  <= '0;
            addr_q    <= '0;
            rs1_q     <= '0;
            zimm_q    <= '0;
            rs1z_q    <= 1'b0;
            priv_q    <= '0;
            rdata_q   <= '0;
            illegal_q <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            funct3_q  <= funct3_d;
            addr_q    <= addr_d;
            rs1_q     <= rs1_d;
            zimm_q    <= zimm_d;
            rs1z_q    <= rs1z_d;
            priv_q    <= priv_d;
            rdata_q   <= rdata_d;
            illegal_q <= illegal_d;
            wdata_q   <= wdata_d;
        end
    end

    // Gated by RSTn so a reset landing in WRITE can never leak a write into the bank.
    assign csr_we       = (state_q == ST_WRITE && RSTn) ? sel : 8'h00;
    assign csr_wdata    = wdata_q;
    assign req_ready    = (state_q == ST_IDLE);
    assign resp_valid   = (state_q == ST_RESP);
    assign resp_rdata   = rdata_q;
    assign resp_illegal = illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit: legal RMW paths, illegal cases, backpressure and reset.
module tb_csr_access_unit;

    logic        CLK = 1'b0;
    logic        RSTn;
    logic        req_valid, req_ready;
    logic [2:0]  req_funct3;
    logic [11:0] req_addr;
    logic [31:0] req_rs1;
    logic [4:0]  req_zimm;
    logic        req_rs1_idx_zero;
    logic [1:0]  req_priv;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_illegal;
    logic [31:0] csr_rd_mstatus, csr_rd_misa, csr_rd_mie, csr_rd_mip;
    logic [31:0] csr_rd_mvendorid, csr_rd_marchid, csr_rd_mimpid, csr_rd_mhartid;
    logic [7:0]  csr_we;
    logic [31:0] csr_wdata;

    int errors = 0;
    int checks = 0;

    csr_access_unit dut (
        .CLK(CLK), .RSTn(RSTn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_rs1(req_rs1),
        .req_zimm(req_zimm), .req_rs1_idx_zero(req_rs1_idx_zero), .req_priv(req_priv),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_illegal(resp_illegal),
        .csr_rd_mstatus(csr_rd_mstatus), .csr_rd_misa(csr_rd_misa),
        .csr_rd_mie(csr_rd_mie), .csr_rd_mip(csr_rd_mip),
        .csr_rd_mvendorid(csr_rd_mvendorid), .csr_rd_marchid(csr_rd_marchid),
        .csr_rd_mimpid(csr_rd_mimpid), .csr_rd_mhartid(csr_rd_mhartid),
        .csr_we(csr_we), .csr_wdata(csr_wdata)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request for a single cycle, then scramble the request fields.
    task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] rs1,
                         input logic [4:0] zimm, input logic rs1z, input logic [1:0] priv);
        chk("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_funct3 = f3; req_addr = addr; req_rs1 = rs1;
        req_zimm = zimm; req_rs1_idx_zero = rs1z; req_priv = priv;
        tick();
        req_valid = 1'b0; req_funct3 = 3'b100; req_addr = 12'hFFF; req_rs1 = 32'hDEAD_BEEF;
        req_zimm = 5'h1F; req_rs1_idx_zero = ~rs1z; req_priv = 2'd0;
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("idle_after_handshake", {30'd0, req_ready, resp_valid}, 32'h2);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [1:0]  priv;
        string       tag;
    } ill_t;

    ill_t ill_tbl[4];

    initial begin
        ill_tbl[0] = '{3'b001, 12'hF14, 2'd3, "ill_write_ro_mhartid"};
        ill_tbl[1] = '{3'b010, 12'h7C0, 2'd3, "ill_unmapped_7c0"};
        ill_tbl[2] = '{3'b010, 12'h300, 2'd0, "ill_priv_u_mstatus"};
        ill_tbl[3] = '{3'b100, 12'h300, 2'd3, "ill_funct3_100"};

        RSTn = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_funct3 = '0; req_addr = '0; req_rs1 = '0; req_zimm = '0;
        req_rs1_idx_zero = 1'b0; req_priv = 2'd3;
        csr_rd_mstatus = 32'h0; csr_rd_misa = 32'h4000_1100;
        csr_rd_mie = 32'h888; csr_rd_mip = 32'h88;
        csr_rd_mvendorid = 32'h1234; csr_rd_marchid = 32'h0;
        csr_rd_mimpid = 32'h0; csr_rd_mhartid = 32'h5;

        tick(); tick();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_csr_we", {24'd0, csr_we}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_csr_wdata", csr_wdata, 32'd0);
        RSTn = 1'b1;
        tick();

        // CSRRW mstatus <- 0x88
        issue(3'b001, 12'h300, 32'h88, 5'd0, 1'b0, 2'd3);
        chk("rw_n1_we", {24'd0, csr_we}, 32'd0);
        chk("rw_n1_ready", {31'd0, req_ready}, 32'd0);
        tick();
        chk("rw_n2_we", {24'd0, csr_we}, 32'h01);
        chk("rw_n2_wdata", csr_wdata, 32'h88);
        chk("rw_n2_valid", {31'd0, resp_valid}, 32'd0);
        tick();
        chk("rw_n3_valid", {31'd0, resp_valid}, 32'd1);
        chk("rw_n3_rdata", resp_rdata, 32'h0);
        chk("rw_n3_illegal", {31'd0, resp_illegal}, 32'd0);
        chk("rw_n3_we", {24'd0, csr_we}, 32'd0);
        handshake();

        // CSRRS mie with rs1=x0: read only
        issue(3'b010, 12'h304, 32'hFFFF, 5'd0, 1'b1, 2'd3);
        tick();
        chk("rs_x0_we", {24'd0, csr_we}, 32'd0);
        chk("rs_x0_valid", {31'd0, resp_valid}, 32'd1);
        chk("rs_x0_rdata", resp_rdata, 32'h888);
        chk("rs_x0_illegal", {31'd0, resp_illegal}, 32'd0);
        handshake();

        // CSRRS mie |= 0x7000 (register form)
        issue(3'b010, 12'h304, 32'h7000, 5'd0, 1'b0, 2'd3);
        tick();
        chk("rs_we", {24'd0, csr_we}, 32'h04);
        chk("rs_wdata", csr_wdata, 32'h7888);
        tick();
        chk("rs_rdata", resp_rdata, 32'h888);
        handshake();

        // CSRRCI mip, zimm=0x08
        issue(3'b111, 12'h344, 32'hFFFF_FFFF, 5'h08, 1'b0, 2'd3);
        tick();
        chk("rci_we", {24'd0, csr_we}, 32'h08);
        chk("rci_wdata", csr_wdata, 32'h80);
        tick();
        chk("rci_valid", {31'd0, resp_valid}, 32'd1);
        chk("rci_rdata", resp_rdata, 32'h88);
        handshake();

        // CSRRWI misa, zimm=0x1F
        issue(3'b101, 12'h301, 32'h0, 5'h1F, 1'b1, 2'd3);
        tick();
        chk("rwi_we", {24'd0, csr_we}, 32'h02);
        chk("rwi_wdata", csr_wdata, 32'h1F);
        tick();
        chk("rwi_rdata", resp_rdata, 32'h4000_1100);
        handshake();

        // CSRRSI mvendorid with zimm=0 is a legal read of a read-only CSR
        issue(3'b110, 12'hF11, 32'h0, 5'h00, 1'b0, 2'd3);
        tick();
        chk("rsi0_ro_we", {24'd0, csr_we}, 32'd0);
        chk("rsi0_ro_valid", {31'd0, resp_valid}, 32'd1);
        chk("rsi0_ro_illegal", {31'd0, resp_illegal}, 32'd0);
        chk("rsi0_ro_rdata", resp_rdata, 32'h1234);
        handshake();

        for (int i = 0; i < 4; i++) begin
            issue(ill_tbl[i].f3, ill_tbl[i].addr, 32'h1, 5'd1, 1'b0, ill_tbl[i].priv);
            chk({ill_tbl[i].tag, "_n1_we"}, {24'd0, csr_we}, 32'd0);
            tick();
            chk({ill_tbl[i].tag, "_we"}, {24'd0, csr_we}, 32'd0);
            chk({ill_tbl[i].tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
            chk({ill_tbl[i].tag, "_illegal"}, {31'd0, resp_illegal}, 32'd1);
            chk({ill_tbl[i].tag, "_rdata"}, resp_rdata, 32'd0);
            handshake();
        end

        // Backpressure: response held for 5 cycles while the source CSR changes
        issue(3'b010, 12'h344, 32'h0, 5'd0, 1'b1, 2'd3);
        tick();
        csr_rd_mip = 32'hFFFF_0000;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'd0, resp_valid}, 32'd1);
            chk("stall_rdata", resp_rdata, 32'h88);
            chk("stall_illegal", {31'd0, resp_illegal}, 32'd0);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
            tick();
        end
        handshake();

        // Reset asserted during WRITE abandons the operation
        issue(3'b001, 12'h300, 32'hABCD, 5'd0, 1'b0, 2'd3);
        tick();
        chk("prerst_we", {24'd0, csr_we}, 32'h01);
        RSTn = 1'b0;
        #1;
        chk("rst_in_write_we", {24'd0, csr_we}, 32'd0);
        tick();
        chk("rst_idle_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_idle_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_idle_we", {24'd0, csr_we}, 32'd0);
        RSTn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_valid", {31'd0, resp_valid}, 32'd0);
            chk("post_rst_we", {24'd0, csr_we}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Executes RV32 Zicsr instructions (CSRRW/S/C and immediate forms) against the machine-mode CSR register bank. Sits between the execute stage and the CSR registers (mstatus, misa, mie, mip, mvendorid, marchid, mimpid, mhartid). It decodes the CSR address, checks privilege and read-only rules, performs the read-modify-write, and drives one-hot write enables plus write data into the bank. The old value is returned to the pipeline over a valid/ready response channel.

## Interface
- XLEN, 32, data width of all CSR values
- CLK  in  1  clock
- RSTn  in  1  reset, synchronous, active-low
- req_valid  in  1  CSR instruction available
- req_ready  out  1  unit can accept; high only in IDLE
- req_funct3  in  3  instruction funct3
- req_addr  in  12  CSR address
- req_rs1  in  XLEN  rs1 register value
- req_zimm  in  5  rs1 field as immediate
- req_rs1_idx_zero  in  1  rs1 index is x0 (register forms)
- req_priv  in  2  current privilege (0 U, 1 S, 3 M)
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_rdata  out  XLEN  old CSR value (0 when illegal)
- resp_illegal  out  1  illegal-instruction exception
- csr_rd_mstatus, csr_rd_misa, csr_rd_mie, csr_rd_mip, csr_rd_mvendorid, csr_rd_marchid, csr_rd_mimpid, csr_rd_mhartid  in  XLEN each  current register values
- csr_we  out  8  one-hot write enable, bit order: 0 mstatus, 1 misa, 2 mie, 3 mip, 4 mvendorid, 5 marchid, 6 mimpid, 7 mhartid
- csr_wdata  out  XLEN  write data, shared by all registers

## Operation
- Address map: 0x300 mstatus, 0x301 misa, 0x304 mie, 0x344 mip, 0xF11 mvendorid, 0xF12 marchid, 0xF13 mimpid, 0xF14 mhartid; anything else unmapped.
- funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000/100 illegal.
- src = immediate forms ? zero-extend(zimm) : rs1. RW: src; RS: old | src; RC: old & ~src.
- write_req = RW/RWI always; RS/RC when rs1_idx_zero=0; RSI/RCI when zimm != 0.
- Illegal when any of: bad funct3; unmapped address; req_priv < addr[9:8]; write_req and addr[11:10]==2'b11. Illegal -> no csr_we, resp_rdata=0, resp_illegal=1.
- Writes of a value equal to the old value still pulse csr_we.
- All request fields captured on the accept edge; later changes on req_* ignored.
- FSM: IDLE -> READ on req_valid&&req_ready. READ: latch selected csr_rd_* into old_q, evaluate legality, compute wdata. READ -> WRITE if legal and write_req, else -> RESP. WRITE: csr_we one-hot for exactly one cycle -> RESP. RESP: resp_valid=1 until resp_ready -> IDLE.

## Timing
- Accept edge ends cycle N. READ in N+1. Write path: csr_we high in N+2, bank captures at end of N+2, resp_valid from N+3. No-write/illegal path: resp_valid from N+2.
- Earliest next accept: cycle after resp handshake (req_ready=1 in IDLE only; no overlap).
- resp_rdata/resp_illegal stable while resp_valid=1 and resp_ready=0.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_illegal=0, csr_we=0, csr_wdata=0.
- csr_we forced 0 in any cycle RSTn=0; reset in any state abandons the operation, no late write or response.

## Structure
- my_pkg: CSR address constants, funct3 enum, FSM state enum, CSR index localparams (0-7).
- Sub-module csr_addr_decode (combinational): addr -> 8-bit one-hot select, mapped flag, read-only flag, required privilege.

## Test plan
- Reset 2 cycles -> req_ready=1, resp_valid=0, csr_we=0, resp_rdata=0.
- CSRRW 0x300, rs1=0x88, mstatus=0 -> N+2 csr_we=8'h01, wdata=0x88; N+3 resp rdata=0, illegal=0.
- CSRRS 0x304, rs1_idx_zero=1, mie=0x888 -> no csr_we; resp at N+2 rdata=0x888.
- CSRRCI 0x344, zimm=0x08, mip=0x88 -> csr_we=8'h08, wdata=0x80; resp rdata=0x88.
- Illegal: CSRRW 0xF14; CSRRS 0x7C0; CSRRS 0x300 with priv=0; funct3=100 -> each resp_illegal=1, rdata=0, csr_we=0, resp at N+2.
- resp_ready low 5 cycles -> resp stable, req_ready=0; RSTn low during WRITE -> csr_we=0, IDLE next cycle.
